kdarwin_counter_bank: RTL and testbench
=======================================

Name: kdarwin_counter_bank

Overview:
- Parametrised multi-channel up/down counter bank; successor to the single-channel kernel counter.
- Adds per-channel step size, wrap or saturate mode, a registered threshold hit pulse, sticky overflow/underflow flags, and bank-wide zero reductions.
- Used by kernel control logic for outstanding-transaction credits, tile and burst bookkeeping across several streams in one instance.

Parameters:
- C_CHANNELS, 4, number of independent counters (>=1)
- C_WIDTH, 16, counter width in bits (>=2)
- C_STEP_WIDTH, 4, width of step input (1..C_WIDTH)
- C_INIT, 0, reset/clear value for every channel (C_WIDTH bits)
- C_SATURATE, 0, 0 = modulo-2^C_WIDTH wrap; 1 = clamp at 0 / all-ones

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- clken  in  1  global enable; when low all state holds (including pulses, which drop to 0)
- clear  in  C_CHANNELS  per-channel synchronous return to C_INIT, clears sticky flags
- load  in  C_CHANNELS  per-channel load
- load_value  in  C_CHANNELS*C_WIDTH  flat; channel i at [i*C_WIDTH +: C_WIDTH]
- incr  in  C_CHANNELS  per-channel add step
- decr  in  C_CHANNELS  per-channel subtract step
- step  in  C_STEP_WIDTH  shared step magnitude, zero-extended
- threshold  in  C_WIDTH  shared compare value
- count  out  C_CHANNELS*C_WIDTH  flat registered counts
- is_zero  out  C_CHANNELS  registered, count==0
- is_max  out  C_CHANNELS  registered, count==all-ones
- thr_hit  out  C_CHANNELS  one-cycle pulse when count becomes equal to threshold
- ovf  out  C_CHANNELS  sticky: an increment crossed all-ones
- unf  out  C_CHANNELS  sticky: a decrement crossed 0
- any_zero  out  1  registered OR of next is_zero
- all_zero  out  1  registered AND of next is_zero

Behaviour:
- rst_n low: count=C_INIT on all channels; is_zero/is_max derived from C_INIT; thr_hit=0, ovf=0, unf=0; any_zero/all_zero derived from C_INIT.
- Per-channel priority per enabled cycle: clear > load > (incr xor decr) > hold. incr&decr together = hold, no flag change.
- Inc: sum = count + step in C_WIDTH+1 bits; carry out -> ovf<=1. Wrap: count<=sum[C_WIDTH-1:0]. Saturate: count<=all-ones on carry.
- Dec: step>count -> unf<=1. Wrap: modulo result. Saturate: count<=0.
- step==0 with incr/decr: count unchanged; no flag set.
- load: count<=load_value; ovf/unf unchanged. clear: count<=C_INIT, ovf<=0, unf<=0.
- Latency: 1 cycle. All flags are computed from the next count value and registered with it, so count and flags are always coherent.
- thr_hit: asserted for one cycle when next count equals threshold and (current count differs, or a load/clear occurred). Holding at threshold does not re-pulse. A threshold input change alone does not pulse.
- clken low: count, is_zero, is_max, ovf, unf held; thr_hit forced 0. Control inputs are ignored.
- rst_n asserted mid-operation: immediate async return to reset values. Release is synchronous to clk; the first enabled edge after release acts on its inputs.
- No combinational paths from inputs to outputs.

Decomposition:
- Package kdarwin_counter_pkg holds:
  - typedef enum {CNT_HOLD, CNT_INC, CNT_DEC, CNT_LOAD, CNT_CLEAR} cnt_op_t
  - localparams for zero, one and max values as functions of width
  - function cnt_decode(clear,load,incr,decr) returning cnt_op_t
- Sub-module kdarwin_counter_chan implements one channel: count, is_zero, is_max, thr_hit, ovf, unf, plus a next-is_zero output for the reductions.
- The bank generates C_CHANNELS instances and registers any_zero/all_zero.

Test Plan (C_CHANNELS=2, C_WIDTH=4, C_INIT=0):
- Reset, then release: count=0/0, is_zero=2'b11, all_zero=1, all flags 0; incr ch0 step=3 for 1 cycle -> ch0 count=3 next cycle, is_zero=2'b10, any_zero=1, all_zero=0.
- Wrap mode, load ch0=14, incr step=3 -> count=1, ovf[0]=1 and sticky; clear[0] -> count=0, ovf[0]=0.
- C_SATURATE=1, count=2, decr step=5 -> count=0, unf=1, is_zero=1; incr step=15 from 3 -> count=15, is_max=1, ovf=1.
- threshold=5, ch1 at 4: incr step=1 -> thr_hit[1] pulses once at count=5; hold 3 cycles -> no pulse; load 5 -> pulse again.
- Simultaneous load+incr -> load wins; incr+decr -> hold; clear+load -> C_INIT; clken=0 with incr -> no change, thr_hit=0.
- Assert rst_n low mid-count (ch0=9, ovf=1), async between edges -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/kdarwin_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kdarwin_counter_pkg : shared types and decode for the counter bank          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package kdarwin_counter_pkg;

    localparam int CNT_OP_W      = 3;
    localparam int CNT_MAX_WIDTH = 64;

    // Widest supported constants; users slice them down to their own width.
    localparam logic [CNT_MAX_WIDTH-1:0] CNT_ZERO     = '0;
    localparam logic [CNT_MAX_WIDTH-1:0] CNT_ONE      = 64'd1;
    localparam logic [CNT_MAX_WIDTH-1:0] CNT_ALL_ONES = '1;

    typedef enum logic [CNT_OP_W-1:0] {
        CNT_HOLD  = 3'd0,
        CNT_INC   = 3'd1,
        CNT_DEC   = 3'd2,
        CNT_LOAD  = 3'd3,
        CNT_CLEAR = 3'd4
    } cnt_op_t;

    function automatic cnt_op_t cnt_decode(input logic clear, input logic load,
                                           input logic incr, input logic decr);
        cnt_op_t op;
        if (clear)
            op = CNT_CLEAR;
        else if (load)
            op = CNT_LOAD;
        else if (incr && !decr)
            op = CNT_INC;
        else if (decr && !incr)
            op = CNT_DEC;
        else
            op = CNT_HOLD;
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kdarwin_counter_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kdarwin_counter_bank_if : control and status bundle of the counter bank     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface kdarwin_counter_bank_if #(
    parameter int C_CHANNELS   = 4,
    parameter int C_WIDTH      = 16,
    parameter int C_STEP_WIDTH = 4
);
    logic                            clken;
    logic [C_CHANNELS-1:0]           clear;
    logic [C_CHANNELS-1:0]           load;
    logic [C_CHANNELS*C_WIDTH-1:0]   load_value;
    logic [C_CHANNELS-1:0]           incr;
    logic [C_CHANNELS-1:0]           decr;
    logic [C_STEP_WIDTH-1:0]         step;
    logic [C_WIDTH-1:0]              threshold;

    logic [C_CHANNELS*C_WIDTH-1:0]   count;
    logic [C_CHANNELS-1:0]           is_zero;
    logic [C_CHANNELS-1:0]           is_max;
    logic [C_CHANNELS-1:0]           thr_hit;
    logic [C_CHANNELS-1:0]           ovf;
    logic [C_CHANNELS-1:0]           unf;
    logic                            any_zero;
    logic                            all_zero;

    modport master (
        output clken, clear, load, load_value, incr, decr, step, threshold,
        input  count, is_zero, is_max, thr_hit, ovf, unf, any_zero, all_zero
    );

    modport slave (
        input  clken, clear, load, load_value, incr, decr, step, threshold,
        output count, is_zero, is_max, thr_hit, ovf, unf, any_zero, all_zero
    );
endinterface
`default_nettype wire

// File: rtl/kdarwin_counter_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kdarwin_counter_chan : one up/down counter with flags and threshold pulse   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module kdarwin_counter_chan
    import kdarwin_counter_pkg::*;
#(
    parameter int                 C_WIDTH      = 16,
    parameter int                 C_STEP_WIDTH = 4,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0,
    parameter int                 C_SATURATE   = 0
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    i_clken,
    input  wire logic                    i_clear,
    input  wire logic                    i_load,
    input  wire logic [C_WIDTH-1:0]      i_load_value,
    input  wire logic                    i_incr,
    input  wire logic                    i_decr,
    input  wire logic [C_STEP_WIDTH-1:0] i_step,
    input  wire logic [C_WIDTH-1:0]      i_threshold,
    output logic      [C_WIDTH-1:0]      o_count,
    output logic                         o_is_zero,
    output logic                         o_is_max,
    output logic                         o_thr_hit,
    output logic                         o_ovf,
    output logic                         o_unf,
    output logic                         o_next_zero
);

    localparam logic [C_WIDTH-1:0] c_zero = CNT_ZERO[C_WIDTH-1:0];
    localparam logic [C_WIDTH-1:0] c_max  = CNT_ALL_ONES[C_WIDTH-1:0];

    logic [C_WIDTH-1:0] r_count;
    logic               r_is_zero;
    logic               r_is_max;
    logic               r_thr_hit;
    logic               r_ovf;
    logic               r_unf;

    cnt_op_t            w_op;
    logic [C_WIDTH-1:0] w_step;
    logic [C_WIDTH:0]   w_sum;
    logic [C_WIDTH-1:0] w_diff;
    logic               w_borrow;
    logic [C_WIDTH-1:0] w_next;
    logic               w_ovf_next;
    logic               w_unf_next;
    logic               w_reload;
    logic               w_thr_next;

    always_comb begin
        w_op       = cnt_decode(i_clear, i_load, i_incr, i_decr);
        w_step     = C_WIDTH'(i_step);
        w_sum      = {1'b0, r_count} + {1'b0, w_step};
        w_diff     = r_count - w_step;
        w_borrow   = (w_step > r_count);
        w_next     = r_count;
        w_ovf_next = r_ovf;
        w_unf_next = r_unf;
        w_reload   = 1'b0;
        if (i_clken) begin
            case (w_op)
                CNT_CLEAR: begin
                    w_next     = C_INIT;
                    w_ovf_next = 1'b0;
                    w_unf_next = 1'b0;
                    w_reload   = 1'b1;
                end
                CNT_LOAD: begin
                    w_next   = i_load_value;
                    w_reload = 1'b1;
                end
                CNT_INC: begin
                    w_next = w_sum[C_WIDTH-1:0];
                    if (w_sum[C_WIDTH]) begin
                        w_ovf_next = 1'b1;
                        if (C_SATURATE != 0)
                            w_next = c_max;
                    end
                end
                CNT_DEC: begin
                    w_next = w_diff;
                    if (w_borrow) begin
                        w_unf_next = 1'b1;
                        if (C_SATURATE != 0)
                            w_next = c_zero;
                    end
                end
                default: ;
            endcase
        end
        // A load/clear onto the threshold re-arms the pulse even if the value is unchanged.
        w_thr_next = i_clken && (w_next == i_threshold)
                     && ((w_next != r_count) || w_reload);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= C_INIT;
            r_is_zero <= (C_INIT == c_zero);
            r_is_max  <= (C_INIT == c_max);
            r_thr_hit <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_count   <= w_next;
            r_is_zero <= (w_next == c_zero);
            r_is_max  <= (w_next == c_max);
            r_thr_hit <= w_thr_next;
            r_ovf     <= w_ovf_next;
            r_unf     <= w_unf_next;
        end
    end

    assign o_count     = r_count;
    assign o_is_zero   = r_is_zero;
    assign o_is_max    = r_is_max;
    assign o_thr_hit   = r_thr_hit;
    assign o_ovf       = r_ovf;
    assign o_unf       = r_unf;
    assign o_next_zero = (w_next == c_zero);

endmodule
`default_nettype wire

// File: rtl/kdarwin_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kdarwin_counter_bank : multi-channel up/down counter bank with reductions   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module kdarwin_counter_bank
    import kdarwin_counter_pkg::*;
#(
    parameter int                 C_CHANNELS   = 4,
    parameter int                 C_WIDTH      = 16,
    parameter int                 C_STEP_WIDTH = 4,
    parameter logic [C_WIDTH-1:0] C_INIT       = '0,
    parameter int                 C_SATURATE   = 0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    kdarwin_counter_bank_if.slave   bus
);

    localparam logic c_init_zero = (C_INIT == CNT_ZERO[C_WIDTH-1:0]);

    logic [C_CHANNELS*C_WIDTH-1:0] w_count;
    logic [C_CHANNELS-1:0]         w_is_zero;
    logic [C_CHANNELS-1:0]         w_is_max;
    logic [C_CHANNELS-1:0]         w_thr_hit;
    logic [C_CHANNELS-1:0]         w_ovf;
    logic [C_CHANNELS-1:0]         w_unf;
    logic [C_CHANNELS-1:0]         w_next_zero;
    logic                          r_any_zero;
    logic                          r_all_zero;

    generate
        for (genvar gi = 0; gi < C_CHANNELS; gi++) begin : g_chan
            kdarwin_counter_chan #(
                .C_WIDTH      (C_WIDTH),
                .C_STEP_WIDTH (C_STEP_WIDTH),
                .C_INIT       (C_INIT),
                .C_SATURATE   (C_SATURATE)
            ) u_chan (
                .clk          (clk),
                .rst_n        (rst_n),
                .i_clken      (bus.clken),
                .i_clear      (bus.clear[gi]),
                .i_load       (bus.load[gi]),
                .i_load_value (bus.load_value[gi*C_WIDTH +: C_WIDTH]),
                .i_incr       (bus.incr[gi]),
                .i_decr       (bus.decr[gi]),
                .i_step       (bus.step),
                .i_threshold  (bus.threshold),
                .o_count      (w_count[gi*C_WIDTH +: C_WIDTH]),
                .o_is_zero    (w_is_zero[gi]),
                .o_is_max     (w_is_max[gi]),
                .o_thr_hit    (w_thr_hit[gi]),
                .o_ovf        (w_ovf[gi]),
                .o_unf        (w_unf[gi]),
                .o_next_zero  (w_next_zero[gi])
            );
        end
    endgenerate

    // Reductions use next-state zero so they stay coherent with the counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_zero <= c_init_zero;
            r_all_zero <= c_init_zero;
        end else begin
            r_any_zero <= |w_next_zero;
            r_all_zero <= &w_next_zero;
        end
    end

    assign bus.count    = w_count;
    assign bus.is_zero  = w_is_zero;
    assign bus.is_max   = w_is_max;
    assign bus.thr_hit  = w_thr_hit;
    assign bus.ovf      = w_ovf;
    assign bus.unf      = w_unf;
    assign bus.any_zero = r_any_zero;
    assign bus.all_zero = r_all_zero;

endmodule
`default_nettype wire

// File: tb/tb_kdarwin_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_kdarwin_counter_bank : directed vectors for wrap and saturate banks      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_kdarwin_counter_bank;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    kdarwin_counter_bank_if #(.C_CHANNELS(2), .C_WIDTH(4), .C_STEP_WIDTH(4)) bw ();
    kdarwin_counter_bank_if #(.C_CHANNELS(2), .C_WIDTH(4), .C_STEP_WIDTH(4)) bs ();

    kdarwin_counter_bank #(
        .C_CHANNELS(2), .C_WIDTH(4), .C_STEP_WIDTH(4), .C_INIT(4'd0), .C_SATURATE(0)
    ) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bw)
    );

    kdarwin_counter_bank #(
        .C_CHANNELS(2), .C_WIDTH(4), .C_STEP_WIDTH(4), .C_INIT(4'd0), .C_SATURATE(1)
    ) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clken;
        logic [1:0]  clear;
        logic [1:0]  load;
        logic [7:0]  lv;
        logic [1:0]  incr;
        logic [1:0]  decr;
        logic [3:0]  step;
        logic [3:0]  thr;
        logic [19:0] exp;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    // exp layout: {count[7:0], is_zero, is_max, thr_hit, ovf, unf, any_zero, all_zero}
    function automatic vec_t mk(input logic ce, input logic [1:0] clr, input logic [1:0] ld,
                                input logic [7:0] lv, input logic [1:0] inc, input logic [1:0] dec,
                                input logic [3:0] st, input logic [3:0] th,
                                input logic [7:0] cnt, input logic [1:0] z, input logic [1:0] mx,
                                input logic [1:0] th_hit, input logic [1:0] ov, input logic [1:0] un,
                                input logic anz, input logic alz);
        vec_t v;
        v.clken = ce; v.clear = clr; v.load = ld; v.lv = lv;
        v.incr = inc; v.decr = dec; v.step = st; v.thr = th;
        v.exp = {cnt, z, mx, th_hit, ov, un, anz, alz};
        return v;
    endfunction

    function automatic logic [19:0] obs_w();
        return {bw.count, bw.is_zero, bw.is_max, bw.thr_hit, bw.ovf, bw.unf,
                bw.any_zero, bw.all_zero};
    endfunction

    function automatic logic [7:0] obs_s();
        return {bs.count[3:0], bs.is_zero[0], bs.is_max[0], bs.ovf[0], bs.unf[0]};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic sat_step(input logic ld, input logic [3:0] lv, input logic inc,
                            input logic dec, input logic [3:0] st, input int idx,
                            input logic [7:0] exp);
        bs.load = {1'b0, ld}; bs.load_value = {4'h0, lv};
        bs.incr = {1'b0, inc}; bs.decr = {1'b0, dec}; bs.step = st;
        @(posedge clk);
        @(negedge clk);
        check("sat", idx, {24'h0, obs_s()}, {24'h0, exp});
        bs.load = '0; bs.incr = '0; bs.decr = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = mk(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 4'd3,  4'd5,  8'h03, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        vecs[1]  = mk(1, 2'b00, 2'b01, 8'h0E, 2'b00, 2'b00, 4'd0,  4'd5,  8'h0E, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        vecs[2]  = mk(1, 2'b00, 2'b00, 8'h00, 2'b01, 2'b00, 4'd3,  4'd5,  8'h01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 1, 0);
        vecs[3]  = mk(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 4'd0,  4'd5,  8'h01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 1, 0);
        vecs[4]  = mk(1, 2'b01, 2'b00, 8'h00, 2'b00, 2'b00, 4'd0,  4'd5,  8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1);
        vecs[5]  = mk(1, 2'b00, 2'b10, 8'h40, 2'b00, 2'b00, 4'd0,  4'd5,  8'h40, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        vecs[6]  = mk(1, 2'b00, 2'b00, 8'h00, 2'b10, 2'b00, 4'd1,  4'd5,  8'h50, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 1, 0);
        vecs[7]  = mk(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 4'd0,  4'd5,  8'h50, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        vecs[8]  = mk(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 4'd0,  4'd5,  8'h50, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        vecs[9]  = mk(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 4'd0,  4'd5,  8'h50, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        vecs[10] = mk(1, 2'b00, 2'b10, 8'h50, 2'b00, 2'b00, 4'd0,  4'd5,  8'h50, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 1, 0);
        vecs[11] = mk(1, 2'b00, 2'b10, 8'h90, 2'b10, 2'b00, 4'd1,  4'd5,  8'h90, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        vecs[12] = mk(1, 2'b00, 2'b00, 8'h00, 2'b10, 2'b10, 4'd2,  4'd5,  8'h90, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
        vecs[13] = mk(1, 2'b10, 2'b10, 8'h70, 2'b00, 2'b00, 4'd0,  4'd5,  8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1);
        vecs[14] = mk(0, 2'b00, 2'b00, 8'h00, 2'b11, 2'b00, 4'd3,  4'd5,  8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1);
        vecs[15] = mk(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b01, 4'd1,  4'd5,  8'h0F, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 1, 0);
        vecs[16] = mk(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b00, 4'd0,  4'd15, 8'h0F, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 1, 0);
        vecs[17] = mk(1, 2'b00, 2'b00, 8'h00, 2'b00, 2'b01, 4'd0,  4'd5,  8'h0F, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 1, 0);
        vecs[18] = mk(0, 2'b00, 2'b01, 8'h05, 2'b00, 2'b00, 4'd0,  4'd5,  8'h0F, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 1, 0);
        vecs[19] = mk(1, 2'b00, 2'b00, 8'h00, 2'b10, 2'b00, 4'd15, 4'd5,  8'hFF, 2'b00, 2'b11, 2'b00, 2'b00, 2'b01, 0, 0);
        vecs[20] = mk(1, 2'b00, 2'b00, 8'h00, 2'b10, 2'b00, 4'd1,  4'd5,  8'h0F, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 1, 0);
        vecs[21] = mk(1, 2'b00, 2'b01, 8'h09, 2'b00, 2'b00, 4'd0,  4'd5,  8'h09, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 1, 0);

        rst_n = 1'b0;
        bw.clken = 1'b1; bw.clear = '0; bw.load = '0; bw.load_value = '0;
        bw.incr = '0; bw.decr = '0; bw.step = '0; bw.threshold = 4'd5;
        bs.clken = 1'b1; bs.clear = '0; bs.load = '0; bs.load_value = '0;
        bs.incr = '0; bs.decr = '0; bs.step = '0; bs.threshold = 4'd5;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_state", 0, {12'h0, obs_w()}, {12'h0, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1});

        for (int i = 0; i < NVEC; i++) begin
            bw.clken = vecs[i].clken; bw.clear = vecs[i].clear; bw.load = vecs[i].load;
            bw.load_value = vecs[i].lv; bw.incr = vecs[i].incr; bw.decr = vecs[i].decr;
            bw.step = vecs[i].step; bw.threshold = vecs[i].thr;
            @(posedge clk);
            @(negedge clk);
            check("vec", i, {12'h0, obs_w()}, {12'h0, vecs[i].exp});
        end
        bw.clken = 1'b1; bw.clear = '0; bw.load = '0; bw.incr = '0; bw.decr = '0;
        bw.step = '0; bw.threshold = 4'd5;

        // Saturating bank: clamp at zero on underflow, at all-ones on overflow.
        sat_step(1'b1, 4'd2, 1'b0, 1'b0, 4'd0,  0, {4'd2,  1'b0, 1'b0, 1'b0, 1'b0});
        sat_step(1'b0, 4'd0, 1'b0, 1'b1, 4'd5,  1, {4'd0,  1'b1, 1'b0, 1'b0, 1'b1});
        sat_step(1'b1, 4'd3, 1'b0, 1'b0, 4'd0,  2, {4'd3,  1'b0, 1'b0, 1'b0, 1'b1});
        sat_step(1'b0, 4'd0, 1'b1, 1'b0, 4'd15, 3, {4'd15, 1'b0, 1'b1, 1'b1, 1'b1});
        sat_step(1'b0, 4'd0, 1'b1, 1'b0, 4'd1,  4, {4'd15, 1'b0, 1'b1, 1'b1, 1'b1});

        // Asynchronous reset between edges with ch0=9 and sticky flags set.
        check("pre_reset", 0, {12'h0, obs_w()}, {12'h0, 8'h09, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 1'b1, 1'b0});
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 0, {12'h0, obs_w()}, {12'h0, 8'h00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1});
        check("async_reset_sat", 0, {24'h0, obs_s()}, {24'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        bw.incr = 2'b01; bw.step = 4'd2;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_incr", 0, {12'h0, obs_w()}, {12'h0, 8'h02, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0});
        bw.incr = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
